// File: rtl/pixel_scaler_pkg.sv
// Shared types and sizing helpers for the pixel_scaler line-buffered upscaler.
package pixel_scaler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } fetch_state_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Memory words per source row.
    function automatic int wpr(input int src_w, input int pix_per_word);
        return src_w / pix_per_word;
    endfunction

endpackage

// File: rtl/line_buffer_pp.sv
// Ping-pong line buffer: two banks of one source row, word-wide write, pixel-wide read.
module line_buffer_pp
    import pixel_scaler_pkg::*;
#(
    parameter int SRC_W        = 64,
    parameter int PIX_W        = 4,
    parameter int PIX_PER_WORD = 8,
    localparam int WPR = wpr(SRC_W, PIX_PER_WORD),
    localparam int WW  = cw(WPR),
    localparam int CW  = cw(SRC_W),
    localparam int KW  = cw(PIX_PER_WORD)
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic                          wr_bank,
    input  logic [WW-1:0]                 wr_word,
    input  logic [PIX_W*PIX_PER_WORD-1:0] wr_data,
    input  logic                          rd_bank,
    input  logic [CW-1:0]                 rd_col,
    output logic [PIX_W-1:0]              rd_pix
);

    logic [PIX_W*PIX_PER_WORD-1:0] mem [2][WPR];
    logic [WW-1:0]                 rd_word;
    logic [KW-1:0]                 rd_k;
    logic [PIX_W*PIX_PER_WORD-1:0] rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_word] <= wr_data;
    end

    assign rd_word = WW'(rd_col / PIX_PER_WORD);
    assign rd_k    = KW'(rd_col % PIX_PER_WORD);
    assign rd_data = mem[rd_bank][rd_word];
    assign rd_pix  = rd_data[rd_k*PIX_W +: PIX_W];

endmodule

// File: rtl/pixel_scaler.sv
// Line-buffered pixel upscaler: fetches source rows over req/ack, replicates SCALE_X x SCALE_Y.
// Build option PIXEL_SCALER_UNDERRUN_EN: sticky underrun flag and UNDERRUN_PIX substitution.
module pixel_scaler
    import pixel_scaler_pkg::*;
#(
    parameter int SRC_W        = 64,
    parameter int SRC_H        = 48,
    parameter int PIX_W        = 4,
    parameter int PIX_PER_WORD = 8,
    parameter int SCALE_X      = 10,
    parameter int SCALE_Y      = 10,
    parameter int ADDR_W       = 9,
    parameter logic [PIX_W-1:0] UNDERRUN_PIX = '0
) (
    input  logic                          clk_25,
    input  logic                          rst,
    input  logic                          disp_active,
    input  logic                          line_end,
    input  logic                          frame_end,
    output logic [PIX_W-1:0]              pixel_out,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ack,
    input  logic [PIX_W*PIX_PER_WORD-1:0] mem_rdata,
    output logic                          underrun
);

    localparam int WPR = wpr(SRC_W, PIX_PER_WORD);
    localparam int CW  = cw(SRC_W);
    localparam int RW  = cw(SRC_H);
    localparam int HW  = cw(SCALE_X);
    localparam int VW  = cw(SCALE_Y);
    localparam int WW  = cw(WPR);

    localparam logic [CW-1:0] COL_MAX  = CW'(SRC_W - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(SRC_H - 1);
    localparam logic [HW-1:0] HREP_MAX = HW'(SCALE_X - 1);
    localparam logic [VW-1:0] VREP_MAX = VW'(SCALE_Y - 1);
    localparam logic [WW-1:0] WORD_MAX = WW'(WPR - 1);

    logic [CW-1:0] h_col;
    logic [HW-1:0] h_rep;
    logic [RW-1:0] v_row;
    logic [VW-1:0] v_rep;
    logic          disp_bank;
    logic          synced;

    fetch_state_t  fstate;
    logic [WW-1:0] word_idx;
    logic [RW-1:0] fetch_row;
    logic          restart;

    logic          swap;
    logic [RW-1:0] next_row;
    logic [RW-1:0] next_tgt;
    logic          wr_en;
    logic [PIX_W-1:0] rd_pix;
    logic [PIX_W-1:0] pix_sel;

    function automatic logic [ADDR_W-1:0] row_addr(input logic [RW-1:0] r);
        return ADDR_W'(int'(r) * WPR);
    endfunction

    // frame_end wins over a coincident line_end; the last row holds until frame_end.
    always_comb begin
        swap     = frame_end ||
                   (line_end && v_rep == VREP_MAX && v_row != ROW_MAX);
        next_row = frame_end ? '0 : v_row + 1'b1;
        next_tgt = (next_row == ROW_MAX) ? '0 : next_row + 1'b1;
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            disp_bank <= 1'b0;
            synced    <= 1'b0;
            v_row     <= ROW_MAX;
            v_rep     <= VREP_MAX;
            h_col     <= '0;
            h_rep     <= '0;
        end else begin
            if (frame_end) begin
                v_row  <= '0;
                v_rep  <= '0;
                synced <= 1'b1;
            end else if (line_end) begin
                if (v_rep != VREP_MAX) begin
                    v_rep <= v_rep + 1'b1;
                end else if (v_row != ROW_MAX) begin
                    v_rep <= '0;
                    v_row <= v_row + 1'b1;
                end
            end
            if (swap) disp_bank <= ~disp_bank;

            if (disp_active) begin
                if (h_rep == HREP_MAX) begin
                    h_rep <= '0;
                    if (h_col != COL_MAX) h_col <= h_col + 1'b1;
                end else begin
                    h_rep <= h_rep + 1'b1;
                end
            end else begin
                h_rep <= '0;
                h_col <= '0;
            end
        end
    end

    // A swap mid-fetch leaves the handshake open; restart marks the next ack as stale.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            fstate    <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            word_idx  <= '0;
            fetch_row <= '0;
            restart   <= 1'b0;
        end else begin
            if (swap) fetch_row <= next_tgt;
            case (fstate)
                IDLE: begin
                    fstate   <= REQ;
                    mem_req  <= 1'b1;
                    word_idx <= '0;
                    mem_addr <= row_addr(swap ? next_tgt : fetch_row);
                end
                REQ: begin
                    if (mem_ack) begin
                        if (swap || restart) begin
                            word_idx <= '0;
                            mem_addr <= row_addr(swap ? next_tgt : fetch_row);
                            restart  <= 1'b0;
                        end else if (word_idx == WORD_MAX) begin
                            fstate  <= DONE;
                            mem_req <= 1'b0;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end else if (swap) begin
                        restart <= 1'b1;
                    end
                end
                DONE: begin
                    if (swap) begin
                        fstate   <= REQ;
                        mem_req  <= 1'b1;
                        word_idx <= '0;
                        mem_addr <= row_addr(next_tgt);
                    end
                end
                default: fstate <= IDLE;
            endcase
        end
    end

    assign wr_en = (fstate == REQ) && mem_ack && !restart;

    line_buffer_pp #(
        .SRC_W        (SRC_W),
        .PIX_W        (PIX_W),
        .PIX_PER_WORD (PIX_PER_WORD)
    ) u_lbuf (
        .clk     (clk_25),
        .wr_en   (wr_en),
        .wr_bank (~disp_bank),
        .wr_word (word_idx),
        .wr_data (mem_rdata),
        .rd_bank (disp_bank),
        .rd_col  (h_col),
        .rd_pix  (rd_pix)
    );

`ifdef PIXEL_SCALER_UNDERRUN_EN
    logic bad_row;

    // The row swapped in while the fetcher was not DONE is blanked for all its lines.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            bad_row  <= 1'b0;
            underrun <= 1'b0;
        end else if (swap) begin
            bad_row <= (fstate != DONE);
            if (fstate != DONE) underrun <= 1'b1;
        end
    end

    assign pix_sel = bad_row ? UNDERRUN_PIX : rd_pix;
`else
    logic unused_cfg;

    assign unused_cfg = ^UNDERRUN_PIX;
    assign underrun   = 1'b0;
    assign pix_sel    = rd_pix;
`endif

    always_ff @(posedge clk_25) begin
        if (rst) pixel_out <= '0;
        else     pixel_out <= (disp_active && synced) ? pix_sel : '0;
    end

endmodule
